// File: rtl/beat_phase_decoder.sv
// Consumer of the one-hot four-beat bus. Decodes (beat, instruction class) into
// registered datapath strobes. Optional macro BEAT_CHECK_EN enables the sticky beat_err flag.
module beat_phase_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       t,
  input  logic [1:0]       op,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_rd,
  output logic             alu_en,
  output logic             pc_load,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             wb_en,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [1:0]       phase,
  output logic             beat_err
);

  typedef enum logic {SYNC, RUN} state_t;

  state_t     state_reg;
  logic [3:0] exp_reg;   // held at 4'b0001 while in SYNC, so one compare covers both states
  logic [1:0] op_reg;

  logic       accept;
  logic       mismatch;
  logic [1:0] idx;

  always_comb begin
    accept   = (t == exp_reg);
    mismatch = (state_reg == RUN) && !accept;
    unique case (exp_reg)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= SYNC;
      exp_reg    <= 4'b0001;
      op_reg     <= 2'b00;
      ir_load    <= 1'b0;
      pc_inc     <= 1'b0;
      reg_rd     <= 1'b0;
      alu_en     <= 1'b0;
      pc_load    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      wb_en      <= 1'b0;
      instr_done <= 1'b0;
      instr_cnt  <= '0;
      phase      <= 2'd0;
    end else begin
      ir_load    <= 1'b0;
      pc_inc     <= 1'b0;
      reg_rd     <= 1'b0;
      alu_en     <= 1'b0;
      pc_load    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      wb_en      <= 1'b0;
      instr_done <= 1'b0;
      if (accept) begin
        state_reg <= RUN;
        phase     <= idx;
        exp_reg   <= {exp_reg[2:0], exp_reg[3]};
        unique case (idx)
          2'd0: begin
            ir_load <= 1'b1;
            pc_inc  <= 1'b1;
          end
          2'd1: begin
            reg_rd <= 1'b1;
            op_reg <= op;
          end
          2'd2: begin
            if (op_reg == 2'b11) pc_load <= 1'b1;
            else                 alu_en  <= 1'b1;
          end
          default: begin
            instr_done <= 1'b1;
            instr_cnt  <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            unique case (op_reg)
              2'b00: wb_en <= 1'b1;
              2'b01: begin
                mem_rd <= 1'b1;
                wb_en  <= 1'b1;
              end
              2'b10: mem_wr <= 1'b1;
              default: ;
            endcase
          end
        endcase
      end else if (mismatch) begin
        // A bad beat (even 0001) is never accepted here; the next 0001 restarts.
        state_reg <= SYNC;
        exp_reg   <= 4'b0001;
        phase     <= 2'd0;
      end
    end
  end

`ifdef BEAT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)           beat_err <= 1'b0;
    else if (mismatch) beat_err <= 1'b1;
  end
`else
  assign beat_err = 1'b0;
`endif

endmodule
